// File: rtl/alu_sequencer.sv
// Command-side driver for a combinational ALU: accept one command, hold ALU inputs, capture result, return it.
// Latency: legal opcode -> rsp_valid SETTLE_CYCLES+1 edges after accept (accept edge included); illegal -> next cycle.
// Backpressure: single outstanding command, no buffering; response held until rsp_ready, cmd_ready low meanwhile.
// Optional accumulator operand source enabled by defining macro ALU_SEQ_ACC_EN.
module alu_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPRN_WIDTH    = 6,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_op1,
    input  logic [DATA_WIDTH-1:0] cmd_op2,
    input  logic [OPRN_WIDTH-1:0] cmd_oprn,
    input  logic                  cmd_use_acc,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [OPRN_WIDTH-1:0] alu_oprn,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic            legal;
    logic [DATA_WIDTH-1:0] op1_src;

    // Opcodes 0x01..0x09 are the only ones the ALU implements.
    assign legal = (cmd_oprn != '0) && (cmd_oprn <= OPRN_WIDTH'(9));

`ifdef ALU_SEQ_ACC_EN
    logic [DATA_WIDTH-1:0] acc;

    assign op1_src = cmd_use_acc ? acc : cmd_op1;

    // Accumulator tracks the last successfully computed result; error responses leave it alone.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc <= '0;
        end else if (state == SETTLE && cnt == 4'd0) begin
            acc <= alu_result;
        end
    end
`else
    logic unused_use_acc;

    assign unused_use_acc = cmd_use_acc;
    assign op1_src        = cmd_op1;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; cmd_ready only in IDLE so no accept overlaps a response handshake.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = legal ? SETTLE : RESP;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: ALU inputs move only on a legal accept; response fields move only on entry to RESP.
    always_ff @(posedge CLK) begin
        if (RST) begin
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_oprn   <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            cnt        <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (legal) begin
                            alu_op1  <= op1_src;
                            alu_op2  <= cmd_op2;
                            alu_oprn <= cmd_oprn;
                            cnt      <= 4'(SETTLE_CYCLES - 1);
                        end else begin
                            rsp_result <= '0;
                            rsp_err    <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_err    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and a result scoreboard.
// Two instances: default settle time, and SETTLE_CYCLES=3.
// Latency is counted in rising edges starting with the accept edge.
module tb_alu_sequencer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST;

    logic        a_cmd_valid, a_cmd_ready, a_use_acc, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_op1, a_op2, a_alu_op1, a_alu_op2, a_alu_result, a_rsp_result;
    logic [5:0]  a_oprn, a_alu_oprn;

    logic        b_cmd_valid, b_cmd_ready, b_use_acc, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_op1, b_op2, b_alu_op1, b_alu_op2, b_alu_result, b_rsp_result;
    logic [5:0]  b_oprn, b_alu_oprn;

    function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y, input logic [5:0] op);
        case (op)
            6'h01:   return x + y;
            6'h02:   return x - y;
            6'h03:   return x * y;
            6'h04:   return x >> y;
            6'h05:   return x << y;
            6'h06:   return x & y;
            6'h07:   return x | y;
            6'h08:   return ~(x | y);
            6'h09:   return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign a_alu_result = alu_f(a_alu_op1, a_alu_op2, a_alu_oprn);
    assign b_alu_result = alu_f(b_alu_op1, b_alu_op2, b_alu_oprn);

    alu_sequencer u_a (
        .CLK(CLK), .RST(RST),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_op1(a_op1), .cmd_op2(a_op2), .cmd_oprn(a_oprn), .cmd_use_acc(a_use_acc),
        .alu_op1(a_alu_op1), .alu_op2(a_alu_op2), .alu_oprn(a_alu_oprn), .alu_result(a_alu_result),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_result(a_rsp_result), .rsp_err(a_rsp_err)
    );

    alu_sequencer #(.SETTLE_CYCLES(3)) u_b (
        .CLK(CLK), .RST(RST),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_op1(b_op1), .cmd_op2(b_op2), .cmd_oprn(b_oprn), .cmd_use_acc(b_use_acc),
        .alu_op1(b_alu_op1), .alu_op2(b_alu_op2), .alu_oprn(b_alu_oprn), .alu_result(b_alu_result),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_result(b_rsp_result), .rsp_err(b_rsp_err)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

`ifdef ALU_SEQ_ACC_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a command to instance a and return just after its accept edge.
    task automatic a_send(input logic [31:0] op1, input logic [31:0] op2, input logic [5:0] oprn,
                          input logic use_acc, input logic [31:0] er, input logic ee);
        int n;
        exp_t e;
        n = 0;
        while (!a_cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", {31'd0, a_cmd_ready}, 32'd1);
        a_cmd_valid = 1'b1;
        a_op1       = op1;
        a_op2       = op2;
        a_oprn      = oprn;
        a_use_acc   = use_acc;
        e.res       = er;
        e.err       = ee;
        sbq.push_back(e);
        tick();
        a_cmd_valid = 1'b0;
    endtask

    // Wait for the response, check latency and payload, and finish the handshake if rsp_ready is set.
    task automatic a_collect(input string tag, input int exp_lat);
        int   lat;
        exp_t e;
        lat = 1;
        while (!a_rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        e = '0;
        if (sbq.size() > 0) e = sbq.pop_front();
        chk({tag, "_result"}, a_rsp_result, e.res);
        chk({tag, "_err"}, {31'd0, a_rsp_err}, {31'd0, e.err});
        if (a_rsp_ready) begin
            chk({tag, "_no_ready_in_resp"}, {31'd0, a_cmd_ready}, 32'd0);
            tick();
            chk({tag, "_ready_after"}, {31'd0, a_cmd_ready}, 32'd1);
            chk({tag, "_valid_drop"}, {31'd0, a_rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int   lat;
        exp_t e;

        RST = 1'b1;
        a_cmd_valid = 1'b0; a_op1 = '0; a_op2 = '0; a_oprn = '0; a_use_acc = 1'b0; a_rsp_ready = 1'b0;
        b_cmd_valid = 1'b0; b_op1 = '0; b_op2 = '0; b_oprn = '0; b_use_acc = 1'b0; b_rsp_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_cmd_ready", {31'd0, a_cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, a_rsp_err}, 32'd0);
        chk("rst_rsp_result", a_rsp_result, 32'd0);
        chk("rst_alu_op1", a_alu_op1, 32'd0);
        chk("rst_alu_op2", a_alu_op2, 32'd0);
        chk("rst_alu_oprn", {26'd0, a_alu_oprn}, 32'd0);
        chk("rst_b_cmd_ready", {31'd0, b_cmd_ready}, 32'd1);
        chk("rst_b_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
        RST = 1'b0;
        tick();

        // Add with immediate consumer
        a_rsp_ready = 1'b1;
        a_send(32'd5, 32'd7, 6'h01, 1'b0, 32'd12, 1'b0);
        a_collect("add", 2);
        chk("add_alu_oprn", {26'd0, a_alu_oprn}, 32'h01);

        // Mul with backpressure; product truncates to zero
        a_rsp_ready = 1'b0;
        a_send(32'h10000, 32'h10000, 6'h03, 1'b0, 32'd0, 1'b0);
        a_collect("mul", 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
            chk("bp_rsp_result", a_rsp_result, 32'd0);
            chk("bp_cmd_ready", {31'd0, a_cmd_ready}, 32'd0);
        end
        a_rsp_ready = 1'b1;
        tick();
        chk("bp_idle_cmd_ready", {31'd0, a_cmd_ready}, 32'd1);
        chk("bp_idle_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);

        // Illegal opcodes: just above the legal range, and zero
        a_send(32'd1, 32'd2, 6'h0A, 1'b0, 32'd0, 1'b1);
        a_collect("ill0a", 1);
        chk("ill0a_alu_oprn", {26'd0, a_alu_oprn}, 32'h03);
        chk("ill0a_alu_op1", a_alu_op1, 32'h10000);
        a_send(32'd1, 32'd2, 6'h00, 1'b0, 32'd0, 1'b1);
        a_collect("ill00", 1);

        // Top legal opcode: signed slt
        a_send(32'hFFFF_FFFF, 32'd1, 6'h09, 1'b0, 32'd1, 1'b0);
        a_collect("slt", 2);
        a_send(32'hF0F0_0000, 32'h0F0F_0000, 6'h08, 1'b0, 32'h0000_FFFF, 1'b0);
        a_collect("nor", 2);

        // Reset in SETTLE discards the command
        a_cmd_valid = 1'b1; a_op1 = 32'd9; a_op2 = 32'd4; a_oprn = 6'h02; a_use_acc = 1'b0;
        tick();
        a_cmd_valid = 1'b0;
        chk("mid_in_settle", {31'd0, a_cmd_ready}, 32'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("mid_cmd_ready", {31'd0, a_cmd_ready}, 32'd1);
        chk("mid_alu_op1", a_alu_op1, 32'd0);
        chk("mid_alu_op2", a_alu_op2, 32'd0);
        chk("mid_alu_oprn", {26'd0, a_alu_oprn}, 32'd0);
        tick();
        tick();
        chk("mid_no_late_rsp", {31'd0, a_rsp_valid}, 32'd0);

        // Accumulator operand (acc was cleared by the reset above)
        a_send(32'd3, 32'd4, 6'h01, 1'b0, 32'd7, 1'b0);
        a_collect("acc_add", 2);
        a_send(32'd9, 32'd2, 6'h02, 1'b1, ACC_ON ? 32'd5 : 32'd7, 1'b0);
        a_collect("acc_sub", 2);
        chk("acc_alu_op1", a_alu_op1, ACC_ON ? 32'd7 : 32'd9);

        // Three-cycle settle instance: sll 1<<4
        b_rsp_ready = 1'b1;
        b_cmd_valid = 1'b1; b_op1 = 32'd1; b_op2 = 32'd4; b_oprn = 6'h05; b_use_acc = 1'b0;
        e.res = 32'd16;
        e.err = 1'b0;
        sbq.push_back(e);
        tick();
        b_cmd_valid = 1'b0;
        lat = 1;
        while (!b_rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("s3_lat", lat, 32'd4);
        e = '0;
        if (sbq.size() > 0) e = sbq.pop_front();
        chk("s3_result", b_rsp_result, e.res);
        chk("s3_err", {31'd0, b_rsp_err}, {31'd0, e.err});
        tick();
        chk("s3_ready_after", {31'd0, b_cmd_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
